// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - multi-cycle restoring divider sequencer (DIV/DIVU/REM/REMU)
// One quotient bit per cycle; divide-by-zero and signed overflow bypass the iteration.
module div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             START,
  input  logic [4:0]       ALUOP,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  input  logic             FLUSH,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {ST_IDLE, ST_PREP, ST_CALC, ST_FIX, ST_DONE} state_t;

  state_t           state_q;
  logic [1:0]       op_q;      // bit0: unsigned, bit1: remainder wanted
  logic [WIDTH-1:0] quo_q;     // dividend shifts out as quotient shifts in
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] result_q;
  logic [CW-1:0]    cnt_q;
  logic             qneg_q;
  logic             rneg_q;
  logic             busy_q;
  logic             done_q;

  logic             accept_d;
  logic             is_signed_d;
  logic             ovf_d;
  logic             sub_ok_d;
  logic [WIDTH:0]   shift_d;
  logic [WIDTH-1:0] diff_d;

  always_comb begin
    accept_d    = START && (ALUOP[4:2] == 3'b011);
    is_signed_d = ~op_q[0];
    ovf_d       = is_signed_d && (quo_q == MIN_NEG) && (&dvs_q);
    shift_d     = {rem_q, quo_q[WIDTH-1]};
    sub_ok_d    = shift_d >= {1'b0, dvs_q};
    diff_d      = shift_d[WIDTH-1:0] - dvs_q;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (FLUSH) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          done_q <= 1'b0;
          if (accept_d) begin
            op_q    <= ALUOP[1:0];
            quo_q   <= DATA1;
            dvs_q   <= DATA2;
            busy_q  <= 1'b1;
            state_q <= ST_PREP;
          end else begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_PREP: begin
          if (dvs_q == '0) begin
            result_q <= op_q[1] ? quo_q : '1;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= ST_DONE;
          end else if (ovf_d) begin
            result_q <= op_q[1] ? '0 : MIN_NEG;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= ST_DONE;
          end else begin
            if (is_signed_d && quo_q[WIDTH-1]) quo_q <= -quo_q;
            if (is_signed_d && dvs_q[WIDTH-1]) dvs_q <= -dvs_q;
            qneg_q  <= is_signed_d && (quo_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
            rneg_q  <= is_signed_d && quo_q[WIDTH-1];
            rem_q   <= '0;
            cnt_q   <= '0;
            state_q <= ST_CALC;
          end
        end
        ST_CALC: begin
          rem_q <= sub_ok_d ? diff_d : shift_d[WIDTH-1:0];
          quo_q <= {quo_q[WIDTH-2:0], sub_ok_d};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) state_q <= ST_FIX;
        end
        ST_FIX: begin
          result_q <= op_q[1] ? (rneg_q ? -rem_q : rem_q)
                              : (qneg_q ? -quo_q : quo_q);
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= ST_DONE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign RESULT = result_q;

endmodule
